// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared FSM state encoding, ALU op codes and illegal-op helper.
// No ports; imported by the ALU and the arbiter top.
package alu_arbiter_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_MUL = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    function automatic logic is_illegal(input logic [2:0] sel);
        return sel == 3'd3 || sel == 3'd7;
    endfunction
endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester ports plus the shared response bus.
// Ports: none. Signals: reqN_valid/ready/sel/a/b, rspN_valid/ready, rsp_result/zero/illegal.
// master = requester side, slave = arbiter side.
interface alu_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [2:0]  req0_sel, req1_sel;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp1_valid;
    logic        rsp0_ready, rsp1_ready;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_illegal;
    modport master (
        output req0_valid, req1_valid, req0_sel, req1_sel,
               req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_result, rsp_zero, rsp_illegal
    );
    modport slave (
        input  req0_valid, req1_valid, req0_sel, req1_sel,
               req0_a, req0_b, req1_a, req1_b, rsp0_ready, rsp1_ready,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
               rsp_result, rsp_zero, rsp_illegal
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// alu_arbiter_alu: combinational 32-bit ALU shared by both requesters.
// Ports: sel_i (op code), a_i/b_i (operands) -> result_o, zero_o (result_o == 0).
// Codes 3 and 7 produce 0 here; flagging them is the arbiter's job.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]  sel_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output logic        zero_o
);
    assign result_o = sel_i == OP_AND ? a_i & b_i :
                      sel_i == OP_OR  ? a_i | b_i :
                      sel_i == OP_ADD ? a_i + b_i :
                      sel_i == OP_SUB ? a_i - b_i :
                      sel_i == OP_MUL ? a_i * b_i :
                      sel_i == OP_SLT ? {31'd0, a_i < b_i} : '0;
    assign zero_o = result_o == '0;
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter giving two requesters turns on one shared ALU.
// Ports: clk, rst (async, active-high), bus (alu_arbiter_if.slave: request/response handshakes,
// registered rsp_result/rsp_zero/rsp_illegal shared by both ports).
module alu_arbiter
    import alu_arbiter_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    state_t      state_q, state_d;
    logic        grant_q, grant_d, last_q, last_d;
    logic [2:0]  sel_q, sel_d;
    logic [31:0] a_q, a_d, b_q, b_d, result_q, result_d;
    logic        zero_q, zero_d, illegal_q, illegal_d;
    logic [31:0] alu_result;
    logic        alu_zero, any_req, pick, rsp_done;

    alu_arbiter_alu u_alu (
        .sel_i    (sel_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Readies are combinational, so hold them off while reset is asserted.
    assign any_req  = (bus.req0_valid | bus.req1_valid) & ~rst;
    // On a tie the port that did not win last time goes next.
    assign pick     = (bus.req0_valid & bus.req1_valid) ? ~last_q : bus.req1_valid;
    assign rsp_done = grant_q ? bus.rsp1_ready : bus.rsp0_ready;

    assign bus.req0_ready  = state_q == S_IDLE && any_req && !pick;
    assign bus.req1_ready  = state_q == S_IDLE && any_req && pick;
    assign bus.rsp0_valid  = state_q == S_RESP && !grant_q;
    assign bus.rsp1_valid  = state_q == S_RESP && grant_q;
    assign bus.rsp_result  = result_q;
    assign bus.rsp_zero    = zero_q;
    assign bus.rsp_illegal = illegal_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        sel_d     = sel_q;
        a_d       = a_q;
        b_d       = b_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: if (any_req) begin
                state_d = S_EXEC;
                grant_d = pick;
                sel_d   = pick ? bus.req1_sel : bus.req0_sel;
                a_d     = pick ? bus.req1_a : bus.req0_a;
                b_d     = pick ? bus.req1_b : bus.req0_b;
            end
            S_EXEC: begin
                state_d   = S_RESP;
                illegal_d = is_illegal(sel_q);
                result_d  = illegal_d ? '0 : alu_result;
                zero_d    = illegal_d | alu_zero;
            end
            S_RESP: if (rsp_done) begin
                state_d = S_IDLE;
                last_d  = grant_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            sel_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            sel_q     <= sel_d;
            a_q       <= a_d;
            b_q       <= b_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: table-driven, hand-sequenced and random checks of alu_arbiter.
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    typedef struct {
        logic        v0;
        logic        v1;
        logic [2:0]  s0;
        logic [2:0]  s1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        int          hold;
        logic        g;
        logic [31:0] res;
        logic        zero;
        logic        ill;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic last_g;
    int   total = 0;
    int   passed = 0;
    vec_t tbl[9];
    vec_t t;

    alu_arbiter_if bus();
    alu_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [33:0] ref_alu(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        logic        ill;
        p   = {32'd0, a} * {32'd0, b};
        r   = 32'd0;
        ill = 1'b0;
        case (sel)
            3'd0:    r = a & b;
            3'd1:    r = a | b;
            3'd2:    r = a + b;
            3'd4:    r = a - b;
            3'd5:    r = p[31:0];
            3'd6:    r = (a < b) ? 32'd1 : 32'd0;
            default: ill = 1'b1;
        endcase
        return {ill, r == 32'd0, r};
    endfunction

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_sel = 3'd0; bus.req1_sel = 3'd0;
        bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req1_a = 32'd0; bus.req1_b = 32'd0;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    endtask

    task automatic scramble();
        bus.req0_sel = 3'($urandom); bus.req1_sel = 3'($urandom);
        bus.req0_a = $urandom; bus.req0_b = $urandom;
        bus.req1_a = $urandom; bus.req1_b = $urandom;
    endtask

    task automatic check_idle_outs(input string nm);
        chk1({nm, "_req0_ready"}, bus.req0_ready, 1'b0);
        chk1({nm, "_req1_ready"}, bus.req1_ready, 1'b0);
        chk1({nm, "_rsp0_valid"}, bus.rsp0_valid, 1'b0);
        chk1({nm, "_rsp1_valid"}, bus.rsp1_valid, 1'b0);
    endtask

    // One full transaction; operands scrambled after acceptance, non-granted rsp_ready raised.
    task automatic run_txn(input vec_t v);
        @(negedge clk);
        bus.req0_valid = v.v0; bus.req1_valid = v.v1;
        bus.req0_sel = v.s0; bus.req1_sel = v.s1;
        bus.req0_a = v.a0; bus.req0_b = v.b0; bus.req1_a = v.a1; bus.req1_b = v.b1;
        bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
        #1;
        chk1("accept_req0_ready", bus.req0_ready, !v.g);
        chk1("accept_req1_ready", bus.req1_ready, v.g);
        @(negedge clk);
        scramble();
        if (v.g) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
        #1;
        check_idle_outs("exec");
        for (int i = 0; i <= v.hold; i++) begin
            @(negedge clk);
            scramble();
            if (i == v.hold) begin
                if (v.g) bus.rsp1_ready = 1'b1; else bus.rsp0_ready = 1'b1;
            end
            #1;
            chk1("resp_rsp0_valid", bus.rsp0_valid, !v.g);
            chk1("resp_rsp1_valid", bus.rsp1_valid, v.g);
            chk32("resp_result", bus.rsp_result, v.res);
            chk1("resp_zero", bus.rsp_zero, v.zero);
            chk1("resp_illegal", bus.rsp_illegal, v.ill);
            chk1("resp_req0_ready", bus.req0_ready, 1'b0);
            chk1("resp_req1_ready", bus.req1_ready, 1'b0);
        end
        @(negedge clk);
        idle_inputs();
        last_g = v.g;
        #1;
        check_idle_outs("post");
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b0, OP_ADD, OP_AND, 32'd5, 32'd7, 32'd0, 32'd0, 0, 1'b0, 32'd12, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, OP_AND, OP_SUB, 32'd0, 32'd0, 32'd9, 32'd9, 5, 1'b1, 32'd0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b0, OP_MUL, OP_AND, 32'h10000, 32'h10000, 32'd0, 32'd0, 1, 1'b0, 32'd0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, OP_ADD, OP_SLT, 32'd1, 32'd1, 32'd3, 32'hFFFFFFFF, 0, 1'b1, 32'd1, 1'b0, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 3'd7, OP_OR, 32'd123, 32'd456, 32'd1, 32'd2, 2, 1'b0, 32'd0, 1'b1, 1'b1};
        tbl[5] = '{1'b1, 1'b0, OP_OR, OP_AND, 32'hF0, 32'h0F, 32'd0, 32'd0, 0, 1'b0, 32'hFF, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 1'b1, OP_SUB, OP_ADD, 32'd8, 32'd3, 32'hFFFFFFFF, 32'd1, 0, 1'b1, 32'd0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, OP_AND, 3'd3, 32'd0, 32'd0, 32'd77, 32'd88, 1, 1'b1, 32'd0, 1'b1, 1'b1};
        tbl[8] = '{1'b1, 1'b1, OP_AND, OP_OR, 32'hFF00FF00, 32'h0FF00FF0, 32'd1, 32'd1, 0, 1'b0, 32'h0F000F00, 1'b0, 1'b0};

        idle_inputs();
        rst = 1'b1;
        #1;
        check_idle_outs("reset");
        chk32("reset_result", bus.rsp_result, 32'd0);
        chk1("reset_zero", bus.rsp_zero, 1'b0);
        chk1("reset_illegal", bus.rsp_illegal, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        last_g = 1'b1;

        for (int k = 0; k < 9; k++) run_txn(tbl[k]);

        // Reset while the accepted operation is executing: no response may follow.
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_sel = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd1;
        #1;
        chk1("rstexec_accept", bus.req0_ready, 1'b1);
        @(negedge clk);
        idle_inputs();
        bus.rsp0_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_idle_outs("rstexec");
        chk32("rstexec_result", bus.rsp_result, 32'd0);
        chk1("rstexec_zero", bus.rsp_zero, 1'b0);
        chk1("rstexec_illegal", bus.rsp_illegal, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        last_g = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_idle_outs("rstafter");
        end
        bus.rsp0_ready = 1'b0;

        // Both ports valid every cycle with responses always consumed: grants 0,1,0,1.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) begin
                bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
                bus.req0_sel = OP_ADD; bus.req0_a = 32'd1; bus.req0_b = 32'd2;
                bus.req1_sel = OP_SUB; bus.req1_a = 32'd10; bus.req1_b = 32'd4;
                bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
            end
            #1;
            chk1("alt_req0_ready", bus.req0_ready, (c % 3 == 0) && ((c / 3) % 2 == 0));
            chk1("alt_req1_ready", bus.req1_ready, (c % 3 == 0) && ((c / 3) % 2 == 1));
            chk1("alt_rsp0_valid", bus.rsp0_valid, (c % 3 == 2) && ((c / 3) % 2 == 0));
            chk1("alt_rsp1_valid", bus.rsp1_valid, (c % 3 == 2) && ((c / 3) % 2 == 1));
            if (c % 3 == 2) chk32("alt_result", bus.rsp_result, ((c / 3) % 2 == 0) ? 32'd3 : 32'd6);
        end
        @(negedge clk);
        idle_inputs();
        last_g = 1'b1;

        for (int k = 0; k < 40; k++) begin
            int m;
            m      = $urandom_range(1, 3);
            t.v0   = m[0];
            t.v1   = m[1];
            t.s0   = 3'($urandom_range(0, 7));
            t.s1   = 3'($urandom_range(0, 7));
            t.a0   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            t.b0   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            t.a1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            t.b1   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            t.hold = $urandom_range(0, 2);
            t.g    = (t.v0 && t.v1) ? !last_g : t.v1;
            {t.ill, t.zero, t.res} = ref_alu(t.g ? t.s1 : t.s0, t.g ? t.a1 : t.a0, t.g ? t.b1 : t.b0);
            run_txn(t);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
